// File: rtl/batch_uart_pkg.sv
// Shared types and defaults for the batch UART uploader.
package batch_uart_pkg;

  localparam int CLKS_PER_BIT_DEFAULT = 868;
  localparam int BATCH_SIZE_DEFAULT   = 1000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_LOAD   = 3'd3,
    ST_SEND   = 3'd4,
    ST_NEXT   = 3'd5,
    ST_FINISH = 3'd6
  } state_e;

  // True for the states that make up an active upload (FETCH..NEXT).
  function automatic logic in_upload(input state_e st);
    case (st)
      ST_FETCH, ST_WAIT, ST_LOAD, ST_SEND, ST_NEXT: in_upload = 1'b1;
      default:                                      in_upload = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/batch_uart_uploader_uart_tx.sv
// 8N1 UART transmitter: start bit, 8 data bits LSB first, stop bit.
module uart_tx_8n1
  import batch_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(CLKS_PER_BIT - 2);

  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic [8:0]    shreg_q, shreg_d;

  // Bit timing and shifting; done is raised so it lands on the last stop-bit cycle.
  always_comb begin
    tx_d    = tx_q;
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    done_d  = 1'b0;
    if (busy_q) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        if (bit_q == 4'd9) begin
          busy_d = 1'b0;
          tx_d   = 1'b1;
        end else begin
          bit_d   = bit_q + 4'd1;
          tx_d    = shreg_q[0];
          shreg_d = {1'b1, shreg_q[8:1]};
        end
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      done_d = (bit_q == 4'd9) && (cnt_q == CNT_PRE);
    end else if (tx_start) begin
      busy_d  = 1'b1;
      tx_d    = 1'b0;
      cnt_d   = '0;
      bit_d   = 4'd0;
      shreg_d = {1'b1, tx_data};
    end else begin
      tx_d = 1'b1;
    end
  end

  // Register transmitter state; reset returns the line to idle-high at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      bit_q   <= 4'd0;
      shreg_q <= 9'h1FF;
    end else begin
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
    end
  end

  assign tx      = tx_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule

// File: rtl/batch_uart_uploader.sv
// Uploads one completed TRNG batch from the collector memory over UART.
module batch_uart_uploader
  import batch_uart_pkg::*;
#(
  parameter int BATCH_SIZE   = BATCH_SIZE_DEFAULT,
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic        clk_uart,
  input  logic        rst,
  input  logic        done_async,
  output logic        read_enable,
  output logic [31:0] read_addr,
  input  logic [7:0]  read_data,
  output logic        uart_tx,
  output logic        busy,
  output logic        upload_done,
  output logic [31:0] bytes_sent
);

  localparam logic [31:0] LAST_IDX = 32'(BATCH_SIZE - 1);

  state_e      state_q, state_d;
  logic        done_meta_q, done_meta_d;
  logic        done_s_q, done_s_d;
  logic        done_prev_q, done_prev_d;
  logic        done_rise_s;
  logic [31:0] idx_q, idx_d;
  logic [31:0] bytes_q, bytes_d;
  logic        abort_q, abort_d;
  logic [7:0]  tx_byte_q, tx_byte_d;
  logic        read_en_q, read_en_d;
  logic [31:0] read_addr_q, read_addr_d;
  logic        busy_q, busy_d;
  logic        upload_done_q, upload_done_d;
  logic        tx_start_s;
  logic        tx_busy_s;
  logic        tx_done_s;

  // Synchronizer, upload sequencing and next values of the registered outputs.
  always_comb begin
    done_meta_d = done_async;
    done_s_d    = done_meta_q;
    done_prev_d = done_s_q;
    done_rise_s = done_s_q & ~done_prev_q;
    state_d     = state_q;
    idx_d       = idx_q;
    bytes_d     = bytes_q;
    tx_byte_d   = tx_byte_q;
    tx_start_s  = 1'b0;
    // A done drop mid-upload is remembered; the frame in flight still finishes.
    if (in_upload(state_q) && !done_s_q) begin
      abort_d = 1'b1;
    end else begin
      abort_d = abort_q;
    end
    case (state_q)
      ST_IDLE: begin
        abort_d = 1'b0;
        if (done_rise_s) begin
          idx_d   = 32'd0;
          bytes_d = 32'd0;
          state_d = ST_FETCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: state_d = ST_WAIT;
      ST_WAIT: begin
        tx_byte_d = read_data;
        state_d   = ST_LOAD;
      end
      ST_LOAD: begin
        if (!tx_busy_s) begin
          tx_start_s = 1'b1;
          state_d    = ST_SEND;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_SEND: begin
        if (tx_done_s) begin
          state_d = ST_NEXT;
        end else begin
          state_d = ST_SEND;
        end
      end
      ST_NEXT: begin
        bytes_d = bytes_q + 32'd1;
        if (abort_q) begin
          state_d = ST_IDLE;
        end else if (idx_q == LAST_IDX) begin
          state_d = ST_FINISH;
        end else begin
          idx_d   = idx_q + 32'd1;
          state_d = ST_FETCH;
        end
      end
      ST_FINISH: begin
        if (!done_s_q) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_FINISH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    read_en_d = (state_d == ST_FETCH);
    if (state_d == ST_FETCH) begin
      read_addr_d = idx_d;
    end else begin
      read_addr_d = read_addr_q;
    end
    busy_d        = in_upload(state_d);
    upload_done_d = (state_d == ST_FINISH);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_uart) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      done_meta_q   <= 1'b0;
      done_s_q      <= 1'b0;
      done_prev_q   <= 1'b0;
      idx_q         <= 32'd0;
      bytes_q       <= 32'd0;
      abort_q       <= 1'b0;
      tx_byte_q     <= 8'd0;
      read_en_q     <= 1'b0;
      read_addr_q   <= 32'd0;
      busy_q        <= 1'b0;
      upload_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      done_meta_q   <= done_meta_d;
      done_s_q      <= done_s_d;
      done_prev_q   <= done_prev_d;
      idx_q         <= idx_d;
      bytes_q       <= bytes_d;
      abort_q       <= abort_d;
      tx_byte_q     <= tx_byte_d;
      read_en_q     <= read_en_d;
      read_addr_q   <= read_addr_d;
      busy_q        <= busy_d;
      upload_done_q <= upload_done_d;
    end
  end

  uart_tx_8n1 #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk      (clk_uart),
    .rst      (rst),
    .tx_start (tx_start_s),
    .tx_data  (tx_byte_q),
    .tx       (uart_tx),
    .tx_busy  (tx_busy_s),
    .tx_done  (tx_done_s)
  );

  assign read_enable = read_en_q;
  assign read_addr   = read_addr_q;
  assign busy        = busy_q;
  assign upload_done = upload_done_q;
  assign bytes_sent  = bytes_q;

endmodule

// File: tb/tb_batch_uart_uploader.sv
// Self-checking bench for batch_uart_uploader: small fast instance plus a full-rate bit-timing instance.
module tb_batch_uart_uploader;

  localparam int B  = 4;
  localparam int C  = 4;
  localparam int F  = 10 * C + 4;
  localparam int C2 = 868;

  typedef struct {
    logic [31:0] mem_word;
    logic        abort;
    logic [31:0] exp_sent;
    logic        exp_done;
  } vec_t;

  logic        clk_uart = 1'b0;
  logic        rst;
  logic        done_async, done2;
  logic        read_enable, read_enable2;
  logic [31:0] read_addr, read_addr2;
  logic [7:0]  read_data, read_data2;
  logic        uart_tx, uart_tx2;
  logic        busy, busy2;
  logic        upload_done, upload_done2;
  logic [31:0] bytes_sent, bytes_sent2;

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          ud_count = 0;
  logic [7:0]  mem [0:B-1];
  logic        hist [0:65535];
  int          rd_cyc[$];
  logic [31:0] rd_addr[$];
  logic [7:0]  dec_b[$];
  int          dec_t[$];
  vec_t        vecs[5];

  always #5 clk_uart = ~clk_uart;

  always @(posedge clk_uart) cyc <= cyc + 1;

  batch_uart_uploader #(.BATCH_SIZE(B), .CLKS_PER_BIT(C)) dut (
    .clk_uart(clk_uart), .rst(rst), .done_async(done_async),
    .read_enable(read_enable), .read_addr(read_addr), .read_data(read_data),
    .uart_tx(uart_tx), .busy(busy), .upload_done(upload_done), .bytes_sent(bytes_sent)
  );

  batch_uart_uploader #(.BATCH_SIZE(1), .CLKS_PER_BIT(C2)) dut_slow (
    .clk_uart(clk_uart), .rst(rst), .done_async(done2),
    .read_enable(read_enable2), .read_addr(read_addr2), .read_data(read_data2),
    .uart_tx(uart_tx2), .busy(busy2), .upload_done(upload_done2), .bytes_sent(bytes_sent2)
  );

  // Collector port B model: registered read, data valid the cycle after the strobe.
  always @(posedge clk_uart) begin
    if (read_enable) read_data <= mem[read_addr[1:0]];
    if (read_enable2) read_data2 <= 8'h55;
  end

  // Line history, read log and upload_done activity, sampled mid-cycle.
  always @(negedge clk_uart) begin
    hist[cyc[15:0]] <= uart_tx;
    if (read_enable) begin
      rd_cyc.push_back(cyc);
      rd_addr.push_back(read_addr);
    end
    if (upload_done) ud_count <= ud_count + 1;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk_uart);
  endtask

  function automatic logic hv(input int i);
    logic [15:0] a;
    a = i[15:0];
    return hist[a];
  endfunction

  // Decode 8N1 frames from the recorded line between two cycle stamps.
  task automatic decode(input int lo, input int hi);
    logic [7:0] b;
    int i;
    dec_b.delete();
    dec_t.delete();
    i = lo;
    while (i < hi) begin
      if (hv(i) == 1'b0 && hv(i - 1) == 1'b1) begin
        chk("start_bit", 32'(hv(i + C / 2)), 32'd0);
        for (int k = 0; k < 8; k++) b[k] = hv(i + (k + 1) * C + C / 2);
        chk("stop_bit", 32'(hv(i + 9 * C + C / 2)), 32'd1);
        dec_b.push_back(b);
        dec_t.push_back(i);
        i = i + 10 * C;
      end else begin
        i = i + 1;
      end
    end
  endtask

  // One upload: raise done, optionally drop it during the second frame, check everything.
  task automatic run_row(input vec_t v);
    int tf, rb, ub, n, hold, nf;
    for (int i = 0; i < B; i++) mem[i] = v.mem_word[8*i +: 8];
    @(negedge clk_uart);
    rb = rd_cyc.size();
    ub = ud_count;
    chk("idle_busy", 32'(busy), 32'd0);
    done_async = 1'b1;
    tf = cyc + 3;
    wait_until(tf - 1);
    chk("pre_fetch_busy", 32'(busy), 32'd0);
    wait_until(tf);
    chk("fetch_read_enable", 32'(read_enable), 32'd1);
    chk("fetch_busy", 32'(busy), 32'd1);
    if (v.abort) begin
      wait_until(tf + F + 3 + $urandom_range(0, 30));
      done_async = 1'b0;
      wait_until(tf + 2 * F - 1);
      chk("abort_busy_next", 32'(busy), 32'd1);
      wait_until(tf + 2 * F);
      chk("abort_busy_idle", 32'(busy), 32'd0);
      chk("abort_bytes_sent", bytes_sent, v.exp_sent);
      wait_until(tf + 2 * F + 20);
      chk("abort_bytes_hold", bytes_sent, v.exp_sent);
      chk("abort_line_idle", 32'(uart_tx), 32'd1);
    end else begin
      wait_until(tf + B * F - 1);
      chk("pre_finish_done", 32'(upload_done), 32'd0);
      chk("pre_finish_busy", 32'(busy), 32'd1);
      wait_until(tf + B * F);
      chk("finish_done", 32'(upload_done), 32'd1);
      chk("finish_busy", 32'(busy), 32'd0);
      chk("finish_bytes_sent", bytes_sent, v.exp_sent);
      hold = $urandom_range(10, 60);
      wait_until(tf + B * F + hold);
      chk("finish_hold_done", 32'(upload_done), 32'd1);
      chk("finish_hold_bytes", bytes_sent, v.exp_sent);
      done_async = 1'b0;
      n = cyc;
      wait_until(n + 2);
      chk("finish_exit_late", 32'(upload_done), 32'd1);
      wait_until(n + 3);
      chk("finish_exit", 32'(upload_done), 32'd0);
      chk("finish_exit_bytes", bytes_sent, v.exp_sent);
    end
    nf = int'(v.exp_sent);
    chk("read_count", 32'(rd_cyc.size() - rb), v.exp_sent);
    for (int i = 0; i < nf; i++) begin
      if (rb + i < rd_cyc.size()) begin
        chk("read_addr_order", rd_addr[rb + i], 32'(i));
        chk("read_cycle", 32'(rd_cyc[rb + i]), 32'(tf + i * F));
      end
    end
    decode(tf, tf + nf * F + 4);
    chk("frame_count", 32'(dec_b.size()), v.exp_sent);
    for (int i = 0; i < nf; i++) begin
      if (i < dec_b.size()) begin
        chk("frame_data", 32'(dec_b[i]), 32'(mem[i]));
        chk("frame_start", 32'(dec_t[i]), 32'(tf + 3 + i * F));
      end
    end
    chk("upload_done_seen", 32'(ud_count > ub), 32'(v.exp_done));
  endtask

  initial begin
    int t0, t_prev, cnt;
    logic lvl;
    vecs[0] = '{32'h3CFF01A5, 1'b0, 32'd4, 1'b1};
    vecs[1] = '{32'h3CFF01A5, 1'b0, 32'd4, 1'b1};
    vecs[2] = '{32'($urandom()), 1'b1, 32'd2, 1'b0};
    vecs[3] = '{32'($urandom()), 1'b0, 32'd4, 1'b1};
    vecs[4] = '{32'($urandom()), 1'b1, 32'd2, 1'b0};

    rst = 1'b1;
    done_async = 1'b0;
    done2 = 1'b0;
    for (int i = 0; i < B; i++) mem[i] = 8'h00;
    repeat (3) @(negedge clk_uart);
    chk("reset_uart_tx", 32'(uart_tx), 32'd1);
    chk("reset_read_enable", 32'(read_enable), 32'd0);
    chk("reset_read_addr", read_addr, 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_upload_done", 32'(upload_done), 32'd0);
    chk("reset_bytes_sent", bytes_sent, 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk_uart);

    for (int r = 0; r < 5; r++) run_row(vecs[r]);

    // Reset during the start bit of the second frame abandons the frame.
    for (int i = 0; i < B; i++) mem[i] = vecs[0].mem_word[8*i +: 8];
    @(negedge clk_uart);
    done_async = 1'b1;
    t0 = cyc + 3;
    wait_until(t0 + F + 4);
    chk("mid_start_bit_low", 32'(uart_tx), 32'd0);
    rst = 1'b1;
    done_async = 1'b0;
    @(negedge clk_uart);
    chk("rst_uart_tx", 32'(uart_tx), 32'd1);
    chk("rst_read_enable", 32'(read_enable), 32'd0);
    chk("rst_read_addr", read_addr, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_upload_done", 32'(upload_done), 32'd0);
    chk("rst_bytes_sent", bytes_sent, 32'd0);
    rst = 1'b0;
    cnt = 0;
    repeat (2 * C * 10) begin
      @(negedge clk_uart);
      if (uart_tx !== 1'b1) cnt++;
    end
    chk("rst_line_quiet", 32'(cnt), 32'd0);
    run_row(vecs[0]);

    // Full-rate instance: every bit of a 0x55 frame toggles the line.
    @(negedge clk_uart);
    done2 = 1'b1;
    t0 = cyc + 3;
    wait_until(t0);
    chk("slow_read_enable", 32'(read_enable2), 32'd1);
    chk("slow_read_addr", read_addr2, 32'd0);
    chk("slow_busy", 32'(busy2), 32'd1);
    wait_until(t0 + 2);
    chk("slow_pre_start", 32'(uart_tx2), 32'd1);
    wait_until(t0 + 3);
    chk("slow_start", 32'(uart_tx2), 32'd0);
    t_prev = cyc;
    lvl = 1'b0;
    for (int k = 0; k < 9; k++) begin
      cnt = 0;
      while (uart_tx2 == lvl && cnt < 2 * C2) begin
        @(negedge clk_uart);
        cnt++;
      end
      chk("slow_bit_len", 32'(cyc - t_prev), 32'(C2));
      t_prev = cyc;
      lvl = ~lvl;
    end
    wait_until(t_prev + C2);
    chk("slow_stop_line", 32'(uart_tx2), 32'd1);
    chk("slow_pre_finish", 32'(upload_done2), 32'd0);
    wait_until(t_prev + C2 + 1);
    chk("slow_finish", 32'(upload_done2), 32'd1);
    chk("slow_bytes_sent", bytes_sent2, 32'd1);
    chk("slow_finish_time", 32'(cyc), 32'(t0 + 10 * C2 + 4));
    done2 = 1'b0;
    repeat (5) @(negedge clk_uart);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
